// File: rtl/count_ctrl.sv
// count_ctrl: run/pause/clear/load controller for a binary counter display.
// Debounces three buttons, prescales the clock into count ticks and sequences the counter.
module count_ctrl #(
   parameter logic [23:0] TICK_DIV   = 24'd9999999,
   parameter logic [16:0] DEB_CYCLES = 17'd100000,
   parameter int          CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             btn_run,
   input  logic             btn_clr,
   input  logic             btn_load,
   input  logic [7:0]       load_val,
   input  logic             up_dn,
   output logic [CNT_W-1:0] count,
   output logic             tick,
   output logic             dp_blink,
   output logic             running,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2,
      StLoad  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
   localparam logic [16:0]      DebLast = DEB_CYCLES - 17'd1;

   // Button index: 0 = run, 1 = clr, 2 = load.
   logic [2:0]  btn_raw;
   logic [2:0]  sync1_q, sync2_q;
   logic [2:0]  level_q, level_dly_q;
   logic [2:0]  armed_q;
   logic [2:0]  press;
   logic [16:0] deb_cnt_q [3];
   logic [16:0] arm_cnt_q [3];

   assign btn_raw = {btn_load, btn_clr, btn_run};

   // A button only becomes armed after a debounced-low period, so a button held
   // through reset release cannot generate a press until it is released.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         level_q     <= '0;
         level_dly_q <= '0;
         armed_q     <= '0;
         for (int i = 0; i < 3; i++) begin
            deb_cnt_q[i] <= '0;
            arm_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q     <= btn_raw;
         sync2_q     <= sync1_q;
         level_dly_q <= level_q;
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != level_q[i]) begin
               if (deb_cnt_q[i] == DebLast) begin
                  level_q[i]   <= sync2_q[i];
                  deb_cnt_q[i] <= '0;
               end else begin
                  deb_cnt_q[i] <= deb_cnt_q[i] + 17'd1;
               end
            end else begin
               deb_cnt_q[i] <= '0;
            end

            if (!armed_q[i]) begin
               if (!sync2_q[i] && !level_q[i]) begin
                  if (arm_cnt_q[i] == DebLast) begin
                     armed_q[i] <= 1'b1;
                  end else begin
                     arm_cnt_q[i] <= arm_cnt_q[i] + 17'd1;
                  end
               end else begin
                  arm_cnt_q[i] <= '0;
               end
            end
         end
      end
   end

   assign press = level_q & ~level_dly_q & armed_q;

   logic ev_clr, ev_load, ev_run;
   assign ev_clr  = press[1];
   assign ev_load = press[2] & ~press[1];
   assign ev_run  = press[0] & ~press[1] & ~press[2];

   state_t           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [23:0]      presc_q, presc_d;
   logic             tick_q, tick_d;
   logic             term;
   logic [CNT_W-1:0] load_ext;

   assign load_ext = {{(CNT_W-8){1'b0}}, load_val};
   assign term     = (state_q == StRun) && (presc_q == TICK_DIV);

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tick_d  = 1'b0;
      case (state_q)
         StLoad: begin
            count_d = load_ext;
            state_d = StPause;
         end
         default: begin
            // Any event outranks a coincident terminal count; the tick is dropped.
            if (ev_clr) begin
               state_d = StIdle;
               count_d = '0;
            end else if (ev_load) begin
               state_d = StLoad;
            end else if (ev_run) begin
               state_d = (state_q == StRun) ? StPause : StRun;
            end else if (term) begin
               tick_d  = 1'b1;
               count_d = up_dn ? (count_q + CntOne) : (count_q - CntOne);
            end
         end
      endcase
      presc_d = (state_q == StRun && state_d == StRun && !term) ? (presc_q + 24'd1) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         count_q <= '0;
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
      end
   end

   assign count    = count_q;
   assign tick     = tick_q;
   assign state    = state_q;
   assign running  = (state_q == StRun);
   assign dp_blink = running && (presc_q <= (TICK_DIV >> 1));

endmodule
